// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ clients.
// Each transaction takes three cycles: grant/select (READ), capture/respond
// (RESP), then back to IDLE, where the next winner is picked.
module regfile_read_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ADDR_W-1:0]           rf_read_reg,
    input  logic [DATA_W-1:0]           rf_read_data,
    output logic                        busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]   rf_read_reg_q, rf_read_reg_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic                busy_q, busy_d;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [PTR_W-1:0]    win_c;
    logic                win_found_c;
    int unsigned         cand_c;

    // Unpack the flat index bus into one entry per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
        assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found_c = 1'b0;
        win_c       = '0;
        cand_c      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_c = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found_c && req[PTR_W'(cand_c)]) begin
                win_found_c = 1'b1;
                win_c       = PTR_W'(cand_c);
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/READ/RESP sequence.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        rf_read_reg_d = rf_read_reg_q;
        rr_ptr_d      = rr_ptr_q;
        win_d         = win_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found_c) begin
                    gnt_d         = NUM_REQ'(1) << win_c;
                    rf_read_reg_d = addr_arr[win_c];
                    win_d         = win_c;
                    state_d       = ST_READ;
                end
            end
            ST_READ: begin
                rsp_data_d  = rf_read_data;
                rsp_valid_d = NUM_REQ'(1) << win_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                gnt_d    = '0;
                rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rf_read_reg_q <= '0;
            rr_ptr_q      <= '0;
            win_q         <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rf_read_reg_q <= rf_read_reg_d;
            rr_ptr_q      <= rr_ptr_d;
            win_q         <= win_d;
            busy_q        <= busy_d;
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rf_read_reg = rf_read_reg_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a behavioural register file.
module tb_regfile_read_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [19:0] req_addr;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [63:0] rsp_data;
    logic [4:0]  rf_read_reg;
    logic [63:0] rf_read_data;
    logic        busy;

    logic [63:0] rf_mem [32];

    int checks;
    int failures;

    regfile_read_arbiter #(
        .NUM_REQ(4),
        .ADDR_W (5),
        .DATA_W (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rf_read_reg (rf_read_reg),
        .rf_read_data(rf_read_data),
        .busy        (busy)
    );

    // Register file returns data combinationally from the select.
    assign rf_read_data = rf_mem[rf_read_reg];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[i*5 +: 5] = a;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req = '0;
        req_addr = '0;
        repeat (2) tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=%b", rsp_valid, 4'b0000); end
        checks++; if (rsp_data !== 64'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=%h", rsp_data, 64'h0); end
        checks++; if (rf_read_reg !== 5'd0) begin failures++; $display("FAIL reset_rf_read_reg got=%0d exp=0", rf_read_reg); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_req_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single;
        set_addr(0, 5'd7);
        req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=%b", gnt, 4'b0001); end
        checks++; if (rf_read_reg !== 5'd7) begin failures++; $display("FAIL single_sel got=%0d exp=7", rf_read_reg); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_early_rsp got=%b exp=%b", rsp_valid, 4'b0000); end
        tick();
        checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got=%b exp=%b", rsp_valid, 4'b0001); end
        checks++; if (rsp_data !== 64'hDEAD_BEEF_0000_0007) begin failures++; $display("FAIL single_rsp_data got=%h exp=%h", rsp_data, 64'hDEAD_BEEF_0000_0007); end
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt_resp got=%b exp=%b", gnt, 4'b0001); end
        req = 4'b0000;
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_done got=%b exp=%b", gnt, 4'b0000); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_done got=%b exp=0", busy); end
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_rsp_pulse got=%b exp=%b", rsp_valid, 4'b0000); end
        checks++; if (rsp_data !== 64'hDEAD_BEEF_0000_0007) begin failures++; $display("FAIL single_rsp_hold got=%h exp=%h", rsp_data, 64'hDEAD_BEEF_0000_0007); end
    endtask

    task automatic test_reset_mid_read;
        logic seen;
        set_addr(0, 5'd3);
        req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL midrst_gnt_pre got=%b exp=%b", gnt, 4'b0001); end
        reset = 1'b0;
        #1;
        checks++; if ({gnt, rsp_valid, busy} !== 9'b0) begin failures++; $display("FAIL midrst_ctrl got=%b exp=%b", {gnt, rsp_valid, busy}, 9'b0); end
        checks++; if ({rsp_data, rf_read_reg} !== 69'b0) begin failures++; $display("FAIL midrst_data got=%h/%0d exp=0/0", rsp_data, rf_read_reg); end
        req = 4'b0000;
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_stray_rsp got=%b exp=0", seen); end
        set_addr(1, 5'd4);
        req = 4'b0011;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL midrst_ptr_zero got=%b exp=%b", gnt, 4'b0001); end
        tick();
        checks++; if (rsp_data !== 64'h3333_0000_0000_0003) begin failures++; $display("FAIL midrst_rsp_data got=%h exp=%h", rsp_data, 64'h3333_0000_0000_0003); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_all_continuous;
        int   n;
        int   exp_w;
        logic seen;
        logic [3:0] exp_oh;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_addr(i, 5'(20 + i));
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_w  = t % 4;
            exp_oh = 4'b0001 << exp_w;
            n = 0;
            seen = 1'b0;
            while (!seen && n < 12) begin
                tick();
                n++;
                if (rsp_valid !== 4'b0000) seen = 1'b1;
            end
            checks++; if (!seen) begin failures++; $display("FAIL cont_timeout t=%0d got=none exp=%b", t, exp_oh); end
            checks++; if (rsp_valid !== exp_oh) begin failures++; $display("FAIL cont_order t=%0d got=%b exp=%b", t, rsp_valid, exp_oh); end
            checks++; if (gnt !== exp_oh) begin failures++; $display("FAIL cont_gnt t=%0d got=%b exp=%b", t, gnt, exp_oh); end
            checks++; if (rsp_data !== {32'hC0DE_0000, 32'(20 + exp_w)}) begin failures++; $display("FAIL cont_data t=%0d got=%h exp=%h", t, rsp_data, {32'hC0DE_0000, 32'(20 + exp_w)}); end
            if (t == 0) begin
                checks++; if (n !== 2) begin failures++; $display("FAIL cont_latency got=%0d exp=2", n); end
            end else begin
                checks++; if (n + 1 !== 3) begin failures++; $display("FAIL cont_spacing t=%0d got=%0d exp=3", t, n + 1); end
            end
            if (t == 4) begin
                req = 4'b0000;
                tick();
            end else begin
                req[exp_w] = 1'b0;
                tick();
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_idle_busy t=%0d got=%b exp=0", t, busy); end
                req[exp_w] = 1'b1;
            end
        end
    endtask

    task automatic test_contention;
        set_addr(1, 5'd10);
        req = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL cont1_gnt got=%b exp=%b", gnt, 4'b0010); end
        tick();
        set_addr(0, 5'd11);
        req = 4'b0011;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont1_idle got=%b exp=0", busy); end
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_gnt got=%b exp=%b", gnt, 4'b0001); end
        checks++; if (rf_read_reg !== 5'd11) begin failures++; $display("FAIL wrap_sel got=%0d exp=11", rf_read_reg); end
        tick();
        checks++; if (rsp_data !== 64'hBBBB_0000_0000_000B) begin failures++; $display("FAIL wrap_data got=%h exp=%h", rsp_data, 64'hBBBB_0000_0000_000B); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_abort_late_change;
        set_addr(2, 5'd5);
        req = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL abort_gnt got=%b exp=%b", gnt, 4'b0100); end
        checks++; if (rf_read_reg !== 5'd5) begin failures++; $display("FAIL abort_sel got=%0d exp=5", rf_read_reg); end
        req = 4'b0000;
        set_addr(2, 5'd9);
        tick();
        checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL abort_rsp_valid got=%b exp=%b", rsp_valid, 4'b0100); end
        checks++; if (rsp_data !== 64'h5555_0000_AAAA_0005) begin failures++; $display("FAIL abort_rsp_data got=%h exp=%h", rsp_data, 64'h5555_0000_AAAA_0005); end
        checks++; if (rf_read_reg !== 5'd5) begin failures++; $display("FAIL abort_sel_hold got=%0d exp=5", rf_read_reg); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", busy); end
        req = 4'b1111;
        tick();
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL abort_ptr3 got=%b exp=%b", gnt, 4'b1000); end
        tick();
        req = 4'b0000;
        tick();
    endtask

    task automatic test_index_bounds;
        logic [4:0]  idx_tab [2];
        logic [63:0] dat_tab [2];
        idx_tab[0] = 5'd0;
        idx_tab[1] = 5'd31;
        dat_tab[0] = 64'hFEDC_BA98_7654_3210;
        dat_tab[1] = 64'h8000_0000_0000_001F;
        for (int j = 0; j < 2; j++) begin
            set_addr(3, idx_tab[j]);
            req = 4'b1000;
            tick();
            checks++; if (rf_read_reg !== idx_tab[j]) begin failures++; $display("FAIL bound_sel j=%0d got=%0d exp=%0d", j, rf_read_reg, idx_tab[j]); end
            checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL bound_gnt j=%0d got=%b exp=%b", j, gnt, 4'b1000); end
            tick();
            checks++; if (rsp_valid !== 4'b1000) begin failures++; $display("FAIL bound_rsp_valid j=%0d got=%b exp=%b", j, rsp_valid, 4'b1000); end
            checks++; if (rsp_data !== dat_tab[j]) begin failures++; $display("FAIL bound_data j=%0d got=%h exp=%h", j, rsp_data, dat_tab[j]); end
            req = 4'b0000;
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) rf_mem[i] = {32'hC0DE_0000, 32'(i)};
        rf_mem[0]  = 64'hFEDC_BA98_7654_3210;
        rf_mem[3]  = 64'h3333_0000_0000_0003;
        rf_mem[5]  = 64'h5555_0000_AAAA_0005;
        rf_mem[7]  = 64'hDEAD_BEEF_0000_0007;
        rf_mem[9]  = 64'h9999_0000_0000_0009;
        rf_mem[11] = 64'hBBBB_0000_0000_000B;
        rf_mem[31] = 64'h8000_0000_0000_001F;

        test_reset();
        test_single();
        test_reset_mid_read();
        test_all_continuous();
        test_contention();
        test_abort_late_change();
        test_index_bounds();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
